axi_sram_slave: RTL and testbench

//  AXI3-style 32-bit responder backed by an internal word-addressed SRAM array.

---
 rtl/axi_sram_slave_if.sv | 52 +++++
 rtl/axi_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if
//  Bundles the five AXI3 channels (AR, R, AW, W, B) between a master and the
//  SRAM responder. The clock and reset are not part of the bundle.
//  Modports:
//   master - drives AR/AW/W and rready/bready; receives R/B and the ready signals
//   slave  - the mirror image, used by axi_sram_slave
interface axi_sram_slave_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arburst, arvalid, rready,
      output awid, awaddr, awlen, awburst, awvalid,
      output wid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  arid, araddr, arlen, arburst, arvalid, rready,
      input  awid, awaddr, awlen, awburst, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rresp, rlast, rvalid,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//  AXI3-style 32-bit responder backed by a word-addressed SRAM array of
//  2**(ADDR_W-2) words. One read burst and one write burst may be in flight at
//  once; the two paths are independent state machines.
//  Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset; every output is 0 while low
//   bus     - AXI channels (slave modport of axi_sram_slave_if)
//  Parameters:
//   ADDR_W    - byte-address bits decoded; higher set bits give DECERR
//   INIT_FILE - image name kept for configuration compatibility; the array
//               starts uninitialised
module axi_sram_slave #(
   parameter int    ADDR_W    = 16,
   parameter string INIT_FILE = ""
) (
   input logic             aclk,
   input logic             aresetn,
   axi_sram_slave_if.slave bus
);
   localparam int WORD_W = ADDR_W - 2;
   localparam int WORDS  = 2 ** WORD_W;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [WORDS];

   r_state_t          r_state, r_next;
   logic              live;
   logic [3:0]        r_id;
   logic [WORD_W-1:0] r_word;
   logic [7:0]        r_len, r_count;
   logic              r_incr;
   logic [1:0]        r_resp;
   logic              r_is_last, ar_hs, r_hs;

   w_state_t          w_state, w_next;
   logic [3:0]        w_id;
   logic [WORD_W-1:0] w_word;
   logic [7:0]        w_len, w_count;
   logic              w_incr, w_decerr, w_burst_err, w_proto_err;
   logic              w_is_last, aw_hs, w_hs, b_hs, mem_we;
   logic              unused_bits;

   // Sub-word address bits are ignored: every beat occupies a whole word slot.
   assign unused_bits = ^{bus.araddr[1:0], bus.awaddr[1:0]};

   // The ready outputs must stay low through reset and come up on the first
   // edge after release, so they are qualified by this flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) live <= 1'b0;
      else          live <= 1'b1;
   end

   assign r_is_last = (r_count == r_len);
   assign ar_hs     = (r_state == R_IDLE) && live && bus.arvalid;
   assign r_hs      = (r_state == R_DATA) && bus.rready;

   // Read path registers: latch the AR request, then count beats and advance
   // the word address on each R handshake.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_word  <= '0;
         r_len   <= '0;
         r_count <= '0;
         r_incr  <= 1'b0;
         r_resp  <= 2'b00;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            r_id    <= bus.arid;
            r_word  <= bus.araddr[ADDR_W-1:2];
            r_len   <= bus.arlen;
            r_count <= '0;
            r_incr  <= (bus.arburst == 2'b01);
            if (|bus.araddr[31:ADDR_W]) r_resp <= 2'b11;
            else if (bus.arburst[1])    r_resp <= 2'b10;
            else                        r_resp <= 2'b00;
         end else if (r_hs) begin
            r_count <= r_count + 8'd1;
            if (r_incr) r_word <= r_word + WORD_W'(1);
         end
      end
   end

   // Read data comes straight off the array, so a same-cycle write to the
   // same word is seen only after the edge.
   always_comb begin
      r_next      = r_state;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rid     = '0;
      bus.rdata   = '0;
      bus.rresp   = 2'b00;
      bus.rlast   = 1'b0;
      case (r_state)
         R_IDLE: begin
            bus.arready = live;
            if (ar_hs) r_next = R_DATA;
         end
         R_DATA: begin
            bus.rvalid = 1'b1;
            bus.rid    = r_id;
            bus.rresp  = r_resp;
            bus.rlast  = r_is_last;
            bus.rdata  = (r_resp == 2'b00) ? mem[r_word] : '0;
            if (r_hs && r_is_last) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign w_is_last = (w_count == w_len);
   assign aw_hs     = (w_state == W_IDLE) && live && bus.awvalid;
   assign w_hs      = (w_state == W_DATA) && bus.wvalid;
   assign b_hs      = (w_state == W_RESP) && bus.bready;
   assign mem_we    = w_hs && !w_decerr && !w_burst_err;

   // Write path registers: latch the AW request and error flags, then count
   // beats; a mismatched ID or misplaced wlast flags the burst but still writes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state     <= W_IDLE;
         w_id        <= '0;
         w_word      <= '0;
         w_len       <= '0;
         w_count     <= '0;
         w_incr      <= 1'b0;
         w_decerr    <= 1'b0;
         w_burst_err <= 1'b0;
         w_proto_err <= 1'b0;
      end else begin
         w_state <= w_next;
         if (aw_hs) begin
            w_id        <= bus.awid;
            w_word      <= bus.awaddr[ADDR_W-1:2];
            w_len       <= bus.awlen;
            w_count     <= '0;
            w_incr      <= (bus.awburst == 2'b01);
            w_decerr    <= |bus.awaddr[31:ADDR_W];
            w_burst_err <= bus.awburst[1];
            w_proto_err <= 1'b0;
         end else if (w_hs) begin
            w_count <= w_count + 8'd1;
            if (w_incr) w_word <= w_word + WORD_W'(1);
            if ((bus.wid != w_id) || (bus.wlast != w_is_last)) w_proto_err <= 1'b1;
         end
      end
   end

   // Write FSM outputs; the beat count, not wlast, decides where the burst ends.
   always_comb begin
      w_next      = w_state;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bid     = '0;
      bus.bresp   = 2'b00;
      case (w_state)
         W_IDLE: begin
            bus.awready = live;
            if (aw_hs) w_next = W_DATA;
         end
         W_DATA: begin
            bus.wready = 1'b1;
            if (w_hs && w_is_last) w_next = W_RESP;
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            bus.bid    = w_id;
            if (w_decerr)                        bus.bresp = 2'b11;
            else if (w_burst_err || w_proto_err) bus.bresp = 2'b10;
            else                                 bus.bresp = 2'b00;
            if (b_hs) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Array has no reset: contents survive a reset, including partial bursts.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) mem[w_word][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//  Randomised scoreboard bench for axi_sram_slave (ADDR_W=16). Stimulus tasks
//  push the expected R beats and B responses, worked out from a word-array
//  reference model, into queues; a monitor pops and compares them whenever the
//  DUT presents R or B.
module tb_axi_sram_slave;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;

   axi_sram_slave_if axi();

   axi_sram_slave #(.ADDR_W(16), .INIT_FILE("")) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .bus(axi.slave)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  id;
      logic [1:0]  resp;
      logic        last;
   } r_beat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_rsp_t;

   r_beat_t     r_q[$];
   b_rsp_t      b_q[$];
   logic [31:0] model [16384];
   logic [31:0] w_data [256];
   logic [3:0]  w_strb [256];
   logic [3:0]  w_id_beat [256];
   logic        w_last_beat [256];
   int          compared = 0;
   int          mismatched = 0;
   int          rready_mode = 0;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic note_fail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: bound expired or unexpected event", name);
   endtask

   // Response the bus rules give a burst from its start address and type.
   function automatic logic [1:0] resp_for(input logic [31:0] addr, input logic [1:0] burst);
      if (addr[31:16] != 16'h0) return 2'b11;
      if (burst[1]) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int i);
      return (burst == 2'b01) ? addr + 32'(4 * i) : addr;
   endfunction

   task automatic push_read_expect(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      r_beat_t     e;
      logic [31:0] a;
      logic [1:0]  resp;
      resp = resp_for(addr, burst);
      for (int i = 0; i <= int'(len); i++) begin
         a      = beat_addr(addr, burst, i);
         e.data = (resp == 2'b00) ? model[a[15:2]] : 32'h0;
         e.id   = id;
         e.resp = resp;
         e.last = (i == int'(len));
         r_q.push_back(e);
      end
   endtask

   task automatic push_write_expect(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      b_rsp_t      e;
      logic [31:0] a;
      logic        proto;
      e.id   = id;
      e.resp = resp_for(addr, burst);
      proto  = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (w_id_beat[i] != id || w_last_beat[i] != (i == int'(len))) proto = 1'b1;
         if (e.resp == 2'b00) begin
            a = beat_addr(addr, burst, i);
            for (int b = 0; b < 4; b++)
               if (w_strb[i][b]) model[a[15:2]][8*b +: 8] = w_data[i][8*b +: 8];
         end
      end
      if (e.resp == 2'b00 && proto) e.resp = 2'b10;
      b_q.push_back(e);
   endtask

   task automatic set_beats(input logic [7:0] len, input logic [3:0] id);
      for (int i = 0; i <= int'(len); i++) begin
         w_data[i]      = $urandom;
         w_strb[i]      = 4'hF;
         w_id_beat[i]   = id;
         w_last_beat[i] = (i == int'(len));
      end
   endtask

   task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n;
      @(posedge aclk); #1;
      axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!axi.arready && n < 200) begin @(negedge aclk); n++; end
      if (!axi.arready) begin
         note_fail("ar_timeout");
         axi.arvalid = 1'b0;
      end else begin
         check_output("rvalid_before_ar", 64'(axi.rvalid), 64'd0);
         @(posedge aclk); #1;
         axi.arvalid = 1'b0;
         @(negedge aclk);
         check_output("rvalid_latency", 64'(axi.rvalid), 64'd1);
      end
   endtask

   task automatic drive_aw_w(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input bit gaps);
      int n;
      @(posedge aclk); #1;
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!axi.awready && n < 200) begin @(negedge aclk); n++; end
      if (!axi.awready) begin
         note_fail("aw_timeout");
         axi.awvalid = 1'b0;
         return;
      end
      @(posedge aclk); #1;
      axi.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            axi.wvalid = 1'b0;
            @(posedge aclk); #1;
         end
         axi.wid = w_id_beat[i]; axi.wdata = w_data[i]; axi.wstrb = w_strb[i];
         axi.wlast = w_last_beat[i]; axi.wvalid = 1'b1;
         n = 0;
         @(negedge aclk);
         while (!axi.wready && n < 200) begin @(negedge aclk); n++; end
         if (!axi.wready) begin note_fail("w_timeout"); break; end
         @(posedge aclk); #1;
      end
      axi.wvalid = 1'b0;
      axi.wlast  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((r_q.size() != 0 || b_q.size() != 0 || !axi.arready || !axi.awready) && n < 2000) begin
         @(negedge aclk); n++;
      end
      check_output(name, 64'(r_q.size() == 0 && b_q.size() == 0 && axi.arready && axi.awready), 64'd1);
   endtask

   task automatic apply_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      push_read_expect(id, addr, len, burst);
      drive_ar(id, addr, len, burst);
      wait_done("read_drain");
   endtask

   task automatic apply_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      push_write_expect(id, addr, len, burst);
      drive_aw_w(id, addr, len, burst, 1'b1);
      wait_done("write_drain");
   endtask

   // Master-side ready generation.
   always @(posedge aclk) begin
      #1;
      case (rready_mode)
         1:       axi.rready = 1'b1;
         2:       axi.rready = ~axi.rready;
         default: axi.rready = 1'($urandom_range(0, 1));
      endcase
      axi.bready = 1'($urandom_range(0, 1));
   end

   // Monitor: whatever R or B the DUT presents must be the head of its queue;
   // the head is retired when the handshake completes at the next edge.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (axi.rvalid) begin
            if (r_q.size() == 0) note_fail("r_unexpected");
            else begin
               check_output("rdata", 64'(axi.rdata), 64'(r_q[0].data));
               check_output("rid", 64'(axi.rid), 64'(r_q[0].id));
               check_output("rresp", 64'(axi.rresp), 64'(r_q[0].resp));
               check_output("rlast", 64'(axi.rlast), 64'(r_q[0].last));
               if (axi.rready) void'(r_q.pop_front());
            end
         end
         if (axi.bvalid) begin
            if (b_q.size() == 0) note_fail("b_unexpected");
            else begin
               check_output("bid", 64'(axi.bid), 64'(b_q[0].id));
               check_output("bresp", 64'(axi.bresp), 64'(b_q[0].resp));
               if (axi.bready) void'(b_q.pop_front());
            end
         end
      end
   end

   function automatic logic [63:0] all_outputs();
      return 64'({axi.arready, axi.rvalid, axi.rdata, axi.rid, axi.rresp, axi.rlast,
                  axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp});
   endfunction

   initial begin
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [3:0]  id;
      int          n;

      axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0;
      axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0;
      axi.wvalid = 1'b0; axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;

      // Reset: all outputs low, readies rise one edge after release.
      #12;
      check_output("reset_outputs", all_outputs(), 64'd0);
      @(negedge aclk); #1;
      aresetn = 1'b1;
      check_output("arready_at_release", 64'(axi.arready), 64'd0);
      @(negedge aclk);
      check_output("arready_after_release", 64'(axi.arready), 64'd1);
      check_output("awready_after_release", 64'(axi.awready), 64'd1);

      $display("[TB] INCR read of preloaded words");
      rready_mode = 1;
      set_beats(8'd3, 4'd1);
      w_data[0] = 32'hA0A0A0A0; w_data[1] = 32'hB1B1B1B1; w_data[2] = 32'hC2C2C2C2; w_data[3] = 32'hD3D3D3D3;
      apply_write(4'd1, 32'h100, 8'd3, 2'b01);
      apply_read(4'd3, 32'h100, 8'd3, 2'b01);

      $display("[TB] write then read back with partial strobes");
      set_beats(8'd1, 4'd2);
      w_data[0] = 32'h01020304; w_data[1] = 32'h05060708;
      apply_write(4'd2, 32'h40, 8'd1, 2'b01);
      set_beats(8'd1, 4'd5);
      w_data[0] = 32'h11223344; w_data[1] = 32'hAABBCCDD; w_strb[1] = 4'b0101;
      apply_write(4'd5, 32'h40, 8'd1, 2'b01);
      apply_read(4'd6, 32'h40, 8'd1, 2'b01);

      $display("[TB] backpressure on a len=7 read");
      set_beats(8'd7, 4'd7);
      apply_write(4'd7, 32'h200, 8'd7, 2'b01);
      rready_mode = 2;
      apply_read(4'd8, 32'h200, 8'd7, 2'b01);
      rready_mode = 0;
      apply_read(4'd9, 32'h204, 8'd4, 2'b00);

      $display("[TB] error responses");
      apply_read(4'd10, 32'h0002_0000, 8'd3, 2'b01);
      set_beats(8'd3, 4'd11);
      apply_write(4'd11, 32'h100, 8'd3, 2'b10);
      apply_read(4'd12, 32'h100, 8'd3, 2'b01);
      set_beats(8'd2, 4'd13);
      w_last_beat[0] = 1'b1; w_last_beat[2] = 1'b0;
      apply_write(4'd13, 32'h300, 8'd2, 2'b01);
      apply_read(4'd14, 32'h300, 8'd2, 2'b01);
      set_beats(8'd1, 4'd15);
      w_id_beat[1] = 4'd0;
      apply_write(4'd15, 32'h310, 8'd1, 2'b01);

      $display("[TB] concurrent read and write of one word");
      set_beats(8'd0, 4'd1);
      apply_write(4'd1, 32'h80, 8'd0, 2'b01);
      rready_mode = 1;
      set_beats(8'd0, 4'd4);
      push_read_expect(4'd2, 32'h80, 8'd0, 2'b01);
      push_write_expect(4'd4, 32'h80, 8'd0, 2'b01);
      fork
         drive_ar(4'd2, 32'h80, 8'd0, 2'b01);
         drive_aw_w(4'd4, 32'h80, 8'd0, 2'b01, 1'b0);
      join
      wait_done("concurrent_drain");
      apply_read(4'd3, 32'h80, 8'd0, 2'b01);
      rready_mode = 0;

      $display("[TB] randomised traffic");
      set_beats(8'd63, 4'd0);
      apply_write(4'd0, 32'h1000, 8'd63, 2'b01);
      for (int t = 0; t < 40; t++) begin
         len   = 8'($urandom_range(0, 7));
         burst = 2'($urandom_range(0, 3));
         id    = 4'($urandom);
         addr  = 32'h1000 + 32'(4 * $urandom_range(0, 63 - int'(len)));
         if ($urandom_range(0, 7) == 0) addr = addr | 32'h0001_0000;
         if ($urandom_range(0, 1) == 0) apply_read(id, addr, len, burst);
         else begin
            set_beats(len, id);
            for (int i = 0; i <= int'(len); i++) w_strb[i] = 4'($urandom);
            if ($urandom_range(0, 7) == 0) w_id_beat[$urandom_range(0, int'(len))] = ~id;
            if ($urandom_range(0, 7) == 0) begin
               n = $urandom_range(0, int'(len));
               w_last_beat[n] = ~w_last_beat[n];
            end
            apply_write(id, addr, len, burst);
         end
      end

      $display("[TB] reset during a read burst");
      rready_mode = 1;
      push_read_expect(4'd9, 32'h200, 8'd7, 2'b01);
      drive_ar(4'd9, 32'h200, 8'd7, 2'b01);
      n = 0;
      while (r_q.size() > 6 && n < 200) begin @(negedge aclk); n++; end
      if (r_q.size() > 6) note_fail("reset_beat_wait");
      @(posedge aclk); #2;
      aresetn = 1'b0;
      #1;
      check_output("midburst_reset_outputs", all_outputs(), 64'd0);
      r_q.delete();
      b_q.delete();
      repeat (3) @(negedge aclk);
      #1;
      aresetn = 1'b1;
      check_output("arready_at_rerelease", 64'(axi.arready), 64'd0);
      @(negedge aclk);
      check_output("arready_after_rerelease", 64'(axi.arready), 64'd1);
      apply_read(4'd10, 32'h200, 8'd1, 2'b01);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
